// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: main FSM with optional memory handshake,
// wait-cycle timeout into a sticky FAULT state, ALU decode and NZCV flags.
`timescale 1ns/1ps
module mc_controller #(
    parameter int unsigned HANDSHAKE = 1,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         MemReady,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemRead,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         ALUSrcA,
    output logic         RegWrite,
    output logic         RegByte,
    output logic         Fault,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [2:0]   ALUControl,
    output logic [3:0]   State
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d, wait_inc;
    logic [3:0]         flags_q, flags_d;

    logic [3:0]         cond;
    logic [1:0]         op;
    logic [5:0]         funct;
    logic               flag_n, flag_z, flag_c, flag_v;
    logic               cond_ex_c;
    logic [2:0]         alu_ctl_dec;
    logic               unsupported;
    logic               is_cmp;
    logic               nzcv_all;
    logic               mem_done;
    logic               timeout_hit;

    logic               pc_write_c, adr_src_c, mem_read_c, mem_write_c, ir_write_c;
    logic               alu_src_a_c, reg_write_c, reg_byte_c, fault_c;
    logic [1:0]         result_src_c, alu_src_b_c, imm_src_c, reg_src_c;
    logic [2:0]         alu_control_c;

    // Instruction bits below the Funct field are not needed by the controller.
    logic               unused_instr;
    assign unused_instr = ^Instr[19:12];

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign funct = Instr[25:20];

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // Completing cycle: MemReady with handshake, otherwise the first cycle.
    assign mem_done    = (HANDSHAKE != 0) ? MemReady : 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT));
    assign wait_inc    = (wait_q == {CNT_W{1'b1}}) ? wait_q : wait_q + CNT_W'(1);

    // Condition evaluation against the registered flags.
    always_comb begin
        cond_ex_c = 1'b0;
        case (cond)
            4'b0000: cond_ex_c = flag_z;
            4'b0001: cond_ex_c = !flag_z;
            4'b0010: cond_ex_c = flag_c;
            4'b0011: cond_ex_c = !flag_c;
            4'b0100: cond_ex_c = flag_n;
            4'b0101: cond_ex_c = !flag_n;
            4'b0110: cond_ex_c = flag_v;
            4'b0111: cond_ex_c = !flag_v;
            4'b1000: cond_ex_c = flag_c && !flag_z;
            4'b1001: cond_ex_c = !flag_c || flag_z;
            4'b1010: cond_ex_c = (flag_n == flag_v);
            4'b1011: cond_ex_c = (flag_n != flag_v);
            4'b1100: cond_ex_c = !flag_z && (flag_n == flag_v);
            4'b1101: cond_ex_c = flag_z || (flag_n != flag_v);
            4'b1110: cond_ex_c = 1'b1;
            default: cond_ex_c = 1'b0;
        endcase
    end

    // Data-processing command decode; nzcv_all selects full flag update.
    always_comb begin
        alu_ctl_dec = 3'b000;
        unsupported = 1'b0;
        is_cmp      = 1'b0;
        nzcv_all    = 1'b0;
        case (funct[4:1])
            4'b0100: begin alu_ctl_dec = 3'b000; nzcv_all = 1'b1; end
            4'b0010: begin alu_ctl_dec = 3'b001; nzcv_all = 1'b1; end
            4'b0000: alu_ctl_dec = 3'b010;
            4'b1100: alu_ctl_dec = 3'b011;
            4'b1010: begin alu_ctl_dec = 3'b001; nzcv_all = 1'b1; is_cmp = 1'b1; end
            default: unsupported = 1'b1;
        endcase
    end

    // Next state, wait counter, flag update and per-state control outputs.
    always_comb begin
        state_d       = state_q;
        wait_d        = '0;
        flags_d       = flags_q;
        pc_write_c    = 1'b0;
        adr_src_c     = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        alu_src_a_c   = 1'b0;
        reg_write_c   = 1'b0;
        reg_byte_c    = 1'b0;
        fault_c       = 1'b0;
        result_src_c  = 2'b00;
        alu_src_b_c   = 2'b00;
        alu_control_c = 3'b000;
        imm_src_c     = op;
        reg_src_c     = {(op == 2'b01) && !funct[0], (op == 2'b10)};

        case (state_q)
            S_FETCH: begin
                mem_read_c   = 1'b1;
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (mem_done) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                case (op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b_c = 2'b01;
                state_d     = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src_c  = 1'b1;
                mem_read_c = 1'b1;
                if (mem_done) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = cond_ex_c;
                reg_byte_c   = funct[2];
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = cond_ex_c;
                // A squashed store has nothing to wait for.
                if (!cond_ex_c || mem_done) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b_c   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                alu_control_c = alu_ctl_dec;
                if (funct[0] && cond_ex_c && !unsupported) begin
                    if (nzcv_all) begin
                        flags_d = ALUFlags;
                    end else begin
                        flags_d[3:2] = ALUFlags[3:2];
                    end
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = cond_ex_c && !is_cmp && !unsupported;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_b_c  = 2'b01;
                result_src_c = 2'b10;
                pc_write_c   = cond_ex_c;
                state_d      = S_FETCH;
            end
            default: begin
                fault_c   = 1'b1;
                imm_src_c = 2'b00;
                reg_src_c = 2'b00;
                state_d   = S_FAULT;
            end
        endcase
    end

    // State, wait counter and flags registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            flags_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flags_q <= flags_d;
        end
    end

    // Outputs forced low while reset is held, independent of the clock.
    assign PCWrite    = reset & pc_write_c;
    assign AdrSrc     = reset & adr_src_c;
    assign MemRead    = reset & mem_read_c;
    assign MemWrite   = reset & mem_write_c;
    assign IRWrite    = reset & ir_write_c;
    assign ALUSrcA    = reset & alu_src_a_c;
    assign RegWrite   = reset & reg_write_c;
    assign RegByte    = reset & reg_byte_c;
    assign Fault      = reset & fault_c;
    assign ResultSrc  = reset ? result_src_c  : 2'b00;
    assign ALUSrcB    = reset ? alu_src_b_c   : 2'b00;
    assign ImmSrc     = reset ? imm_src_c     : 2'b00;
    assign RegSrc     = reset ? reg_src_c     : 2'b00;
    assign ALUControl = reset ? alu_control_c : 3'b000;
    assign State      = reset ? state_q       : 4'd0;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: handshake and no-handshake instances.
`timescale 1ns/1ps
module tb_mc_controller;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;

    logic PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, RegByte, Fault;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic nh_pcw, nh_adr, nh_mrd, nh_mwr, nh_irw, nh_asa, nh_rw, nh_rb, nh_flt;
    logic [1:0] nh_rs, nh_asb, nh_imm, nh_rsrc;
    logic [2:0] nh_ctl;
    logic [3:0] nh_state;

    int checks = 0;
    int errors = 0;
    int ldr_seq [6] = '{0, 1, 2, 3, 4, 0};

    wire [23:0] outs_hs = {State, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ALUSrcA,
                           RegWrite, RegByte, Fault, ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};
    wire [23:0] outs_nh = {nh_state, nh_pcw, nh_adr, nh_mrd, nh_mwr, nh_irw, nh_asa,
                           nh_rw, nh_rb, nh_flt, nh_rs, nh_asb, nh_imm, nh_rsrc, nh_ctl};

    always #5 clk = ~clk;

    mc_controller #(.HANDSHAKE(1), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegByte(RegByte),
        .Fault(Fault), .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .State(State)
    );

    mc_controller #(.HANDSHAKE(0), .TIMEOUT(16)) dut_nh (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .PCWrite(nh_pcw), .AdrSrc(nh_adr), .MemRead(nh_mrd), .MemWrite(nh_mwr),
        .IRWrite(nh_irw), .ALUSrcA(nh_asa), .RegWrite(nh_rw), .RegByte(nh_rb),
        .Fault(nh_flt), .ResultSrc(nh_rs), .ALUSrcB(nh_asb), .ImmSrc(nh_imm),
        .RegSrc(nh_rsrc), .ALUControl(nh_ctl), .State(nh_state)
    );

    // Count one comparison and report it when it does not match.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One data-processing instruction from FETCH back to FETCH.
    task automatic do_dp(input logic [19:0] ins, input logic [3:0] alf,
                         input logic [2:0] exp_ctl, input logic exp_rw);
        Instr = ins; ALUFlags = alf; MemReady = 1'b1; #1;
        chk("dp_fetch", 32'(State), 32'd0);
        tick(); chk("dp_decode", 32'(State), 32'd1);
        tick(); chk("dp_exec", 32'(State), ins[13] ? 32'd7 : 32'd6);
        chk("dp_aluctl", 32'(ALUControl), 32'(exp_ctl));
        chk("dp_exec_rw", 32'(RegWrite), 32'd0);
        tick(); chk("dp_aluwb", 32'(State), 32'd8);
        chk("dp_regwrite", 32'(RegWrite), 32'(exp_rw));
        tick(); chk("dp_back", 32'(State), 32'd0);
    endtask

    // One branch instruction from FETCH back to FETCH.
    task automatic do_br(input logic [19:0] ins, input logic exp_pcw);
        Instr = ins; MemReady = 1'b1; #1;
        chk("br_fetch", 32'(State), 32'd0);
        tick(); chk("br_decode", 32'(State), 32'd1);
        tick(); chk("br_state", 32'(State), 32'd9);
        chk("br_pcwrite", 32'(PCWrite), 32'(exp_pcw));
        chk("br_regsrc", 32'(RegSrc), 32'd1);
        tick(); chk("br_back", 32'(State), 32'd0);
    endtask

    initial begin
        reset = 1'b0; Instr = 20'hEC000; ALUFlags = 4'b0000; MemReady = 1'b0;
        #1;
        chk("rst_outs", 32'(outs_hs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs_clk", 32'(outs_hs), 32'd0);
        chk("rst_outs_nh", 32'(outs_nh), 32'd0);

        @(negedge clk); reset = 1'b1; #1;
        chk("rel_state", 32'(State), 32'd0);
        chk("rel_memread", 32'(MemRead), 32'd1);

        // MemReady on the cycle the counter reaches TIMEOUT still completes.
        repeat (16) tick();
        chk("tb_edge_state", 32'(State), 32'd0);
        chk("tb_edge_fault", 32'(Fault), 32'd0);
        MemReady = 1'b1; #1;
        chk("tb_edge_irwrite", 32'(IRWrite), 32'd1);
        chk("tb_edge_pcwrite", 32'(PCWrite), 32'd1);
        tick(); chk("op11_decode", 32'(State), 32'd1);
        chk("op11_strobes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
        tick(); chk("op11_back", 32'(State), 32'd0);

        do_dp(20'hE0811, 4'b0000, 3'b000, 1'b1);   // ADD
        do_dp(20'hF0811, 4'b0000, 3'b000, 1'b0);   // ADD, never
        do_dp(20'hE0211, 4'b0000, 3'b000, 1'b0);   // EOR, unsupported
        do_dp(20'hE0411, 4'b0000, 3'b001, 1'b1);   // SUB
        do_dp(20'hE1811, 4'b0000, 3'b011, 1'b1);   // ORR
        do_dp(20'hE2811, 4'b0000, 3'b000, 1'b1);   // ADD immediate
        do_dp(20'hE1500, 4'b0100, 3'b001, 1'b0);   // CMP -> Z=1
        ALUFlags = 4'b0000;
        do_br(20'h1A000, 1'b0);                    // BNE
        do_br(20'h0A000, 1'b1);                    // BEQ
        do_dp(20'hE0911, 4'b0011, 3'b000, 1'b1);   // ADDS -> 0011
        do_dp(20'hE0111, 4'b1000, 3'b010, 1'b1);   // ANDS -> 1011
        ALUFlags = 4'b0000;
        do_br(20'hAA000, 1'b1);                    // BGE
        do_br(20'hBA000, 1'b0);                    // BLT
        do_br(20'h8A000, 1'b1);                    // BHI

        // STR with MemReady arriving on the fourth MEMWRITE cycle.
        Instr = 20'hE5801; MemReady = 1'b1; #1;
        chk("str_fetch", 32'(State), 32'd0);
        tick(); chk("str_decode", 32'(State), 32'd1);
        tick(); chk("str_memadr", 32'(State), 32'd2);
        chk("str_alusrcb", 32'(ALUSrcB), 32'd1);
        MemReady = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            MemReady = (k == 3); #1;
            chk("str_state", 32'(State), 32'd5);
            chk("str_memwrite", 32'(MemWrite), 32'd1);
            if (k == 0) chk("str_regsrc", 32'(RegSrc), 32'd2);
            tick();
        end
        chk("str_back", 32'(State), 32'd0);
        chk("str_mw_off", 32'(MemWrite), 32'd0);
        chk("str_nofault", 32'(Fault), 32'd0);

        // Reset in the middle of a store aborts it.
        MemReady = 1'b1; #1;
        tick(); tick(); MemReady = 1'b0; tick();
        chk("abort_state", 32'(State), 32'd5);
        reset = 1'b0; #1;
        chk("abort_outs", 32'(outs_hs), 32'd0);
        tick(); chk("abort_outs_clk", 32'(outs_hs), 32'd0);
        @(negedge clk); reset = 1'b1; Instr = 20'hE5D01; #1;
        chk("abort_fetch", 32'(State), 32'd0);
        chk("abort_mw", 32'(MemWrite), 32'd0);

        // LDRB on the no-handshake instance, MemReady low.
        for (int k = 0; k < 6; k++) begin
            chk("ldrb_seq", 32'(nh_state), 32'(ldr_seq[k]));
            if (k == 4) begin
                chk("ldrb_regbyte", 32'(nh_rb), 32'd1);
                chk("ldrb_regwrite", 32'(nh_rw), 32'd1);
            end
            if (k < 5) tick();
        end

        // Handshake instance has been starved in FETCH since the release.
        repeat (11) tick();
        chk("to_state16", 32'(State), 32'd0);
        tick();
        chk("to_fault_outs", 32'(outs_hs), 32'hA00800);
        MemReady = 1'b1;
        tick();
        chk("to_sticky", 32'(State), 32'd10);
        reset = 1'b0; #1;
        chk("to_reset_outs", 32'(outs_hs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter HANDSHAKE, default 1: 1 = memory states wait for MemReady; 0 = memory states take exactly one cycle and MemReady is ignored.
REQ-002 Parameter TIMEOUT, default 16: maximum wait cycles in any memory state; 0 disables the timeout.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low; asserted when low.
REQ-005 Ports Instr[31:12] (in, 20) and ALUFlags[3:0] (in, 4, {N,Z,C,V}); Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20].
REQ-006 Port MemReady, input, 1: memory completes the current access this cycle.
REQ-007 Outputs, 1 bit each: PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ALUSrcA, RegWrite, RegByte, Fault.
REQ-008 Outputs, 2 bits each: ResultSrc, ALUSrcB, ImmSrc, RegSrc. Output ALUControl is 3 bits. Output State is 4 bits (debug encoding).

Function
REQ-009 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, FAULT 10. State SHALL output the current encoding.
REQ-010 FETCH: MemRead=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add. On the completing cycle, assert IRWrite=1 and PCWrite=1 together, then go to DECODE. Otherwise stay in FETCH.
REQ-011 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add. Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH, with no side effects.
REQ-012 MEMADR: ALUSrcA=0, ALUSrcB=01, ALU add. Go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-013 MEMREAD: AdrSrc=1, MemRead=1. Go to MEMWB on the completing cycle; otherwise stay.
REQ-014 MEMWB: ResultSrc=01, RegWrite=CondEx, RegByte=Funct[2]. Then go to FETCH.
REQ-015 MEMWRITE: AdrSrc=1, MemWrite=CondEx, held every cycle until the completing cycle. Then go to FETCH. If CondEx=0, the state completes in one cycle without waiting.
REQ-016 EXECR (ALUSrcB=00) and EXECI (ALUSrcB=01): ALUSrcA=0, ALUControl from decode. Then go to ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=CondEx AND NOT(CMP or unsupported command). Then go to FETCH.
REQ-018 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, ALU add, PCWrite=CondEx. Then go to FETCH.
REQ-019 Completing cycle: HANDSHAKE=1 means MemReady=1 in that cycle; HANDSHAKE=0 means the first cycle in the state.
REQ-020 ALU decode on Funct[4:1]: ADD 0100->000; SUB 0010->001; AND 0000->010; ORR 1100->011; CMP 1010->001. Any other value -> 000, flagged unsupported. Outside EXECR/EXECI, ALUControl=000.
REQ-021 ImmSrc=Op in every state. RegSrc[0]=1 when Op=10. RegSrc[1]=1 when Op=01 and Funct[0]=0.
REQ-022 An internal 4-bit Flags register is updated at the end of EXECR/EXECI when Funct[0]=1, CondEx=1, and the command is supported.
  - ADD/SUB/CMP: all of NZCV from ALUFlags.
  - AND/ORR: N,Z only; C,V hold.
REQ-023 CondEx is combinational from Cond and the registered Flags.
  - Codes 0000-1101 follow the ARM condition table (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE).
  - 1110 -> 1.
  - 1111 -> 0.
REQ-024 A wait counter resets to 0 on entry to any memory state (FETCH, MEMREAD, MEMWRITE) and increments each non-completing cycle.
REQ-025 With TIMEOUT>0, reaching TIMEOUT non-completing cycles moves the FSM to FAULT on the next edge.
REQ-026 FAULT: Fault=1 and all other outputs 0. The state is sticky until reset.
REQ-027 A MemReady arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally; completion takes precedence over timeout.
REQ-028 Outputs not listed for a state are 0.

Reset
REQ-029 While reset is low, all outputs are 0, regardless of clock.
REQ-030 Reset sets state FETCH, Flags 0000, and wait counter 0.
REQ-031 On the first rising edge after reset deasserts, the FSM is in FETCH with MemRead=1.
REQ-032 Reset asserted mid-access SHALL abort the access; no PCWrite, RegWrite, or MemWrite is issued afterwards.

Verification
REQ-033 ADD R1 (Instr 0xE08xxxxx), HANDSHAKE=1, MemReady high -> state sequence 0,1,6,8,0; RegWrite=1 only in ALUWB; ALUControl=000 in EXECR.
REQ-034 STR with MemReady delayed 3 cycles in MEMWRITE -> MemWrite=1 for exactly 4 cycles, then FETCH; no Fault.
REQ-035 CMPS setting Z=1, then BNE -> PCWrite=0 in BRANCH. A following BEQ -> PCWrite=1 in BRANCH.
REQ-036 TIMEOUT=16 and MemReady held low in FETCH -> state 10 and Fault=1 after 16 wait cycles. Reset low -> all outputs 0 immediately.
REQ-037 HANDSHAKE=0, LDRB -> sequence 0,1,2,3,4,0 with one cycle each; RegByte=1 in MEMWB.
REQ-038 Op=11 -> DECODE returns to FETCH with no write strobes. Cond=1111 ADD -> RegWrite=0 in ALUWB.
